// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcode/funct constants, request kinds, encoder states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [3:0] {
        K_ADD  = 4'd0,
        K_SUB  = 4'd1,
        K_AND  = 4'd2,
        K_OR   = 4'd3,
        K_SLT  = 4'd4,
        K_LW   = 4'd5,
        K_SW   = 4'd6,
        K_BEQ  = 4'd7,
        K_ADDI = 4'd8,
        K_J    = 4'd9
    } instr_kind_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
        S_DONE   = 3'd3,
        S_FULL   = 3'd4
    } enc_state_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: symbolic request fields -> 32-bit MIPS word.
module instr_pack
    import mips_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    instr_kind_t k;
    assign k = instr_kind_t'(kind);

    // Select layout by kind; unknown codes produce a zero word and flag illegal.
    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (k)
            K_ADD:   word = {OP_RTYPE, rs, rt, rd, 5'd0, F_ADD};
            K_SUB:   word = {OP_RTYPE, rs, rt, rd, 5'd0, F_SUB};
            K_AND:   word = {OP_RTYPE, rs, rt, rd, 5'd0, F_AND};
            K_OR:    word = {OP_RTYPE, rs, rt, rd, 5'd0, F_OR};
            K_SLT:   word = {OP_RTYPE, rs, rt, rd, 5'd0, F_SLT};
            K_LW:    word = {OP_LW,   rs, rt, imm};
            K_SW:    word = {OP_SW,   rs, rt, imm};
            K_BEQ:   word = {OP_BEQ,  rs, rt, imm};
            K_ADDI:  word = {OP_ADDI, rs, rt, imm};
            K_J:     word = {OP_J, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: accepts requests, writes packed words to
// consecutive instruction-memory addresses.
//
// state  | meaning
// IDLE   | after reset, waits for start
// ACCEPT | req_ready=1, waiting for a request transfer
// WRITE  | one-cycle write of the registered word
// DONE   | last word written, holding until start
// FULL   | DEPTH words written without last, holding until start
module instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    enc_state_t      state;
    logic            we_q;
    logic            last_q;
    logic [31:0]     pack_word;
    logic            pack_illegal;
    logic [ADDR_W:0] count_inc;

    instr_pack u_pack (
        .kind    (req_kind),
        .rs      (req_rs),
        .rt      (req_rt),
        .rd      (req_rd),
        .imm     (req_imm),
        .target  (req_target),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    assign count_inc = count + 1'b1;

    // A start or reset seen during WRITE suppresses the pending strobe in that same cycle.
    assign imem_we = we_q & ~start & reset_n;

    // Encoder FSM with registered handshake, write and status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            we_q      <= 1'b0;
            last_q    <= 1'b0;
            imem_addr <= '0;
            imem_wd   <= 32'h0;
            count     <= '0;
            done      <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
        end else if (start) begin
            state     <= S_ACCEPT;
            req_ready <= 1'b1;
            we_q      <= 1'b0;
            imem_addr <= '0;
            count     <= '0;
            done      <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_ACCEPT: begin
                    if (req_valid) begin
                        if (pack_illegal) begin
                            err <= 1'b1;
                        end else begin
                            imem_wd   <= pack_word;
                            last_q    <= req_last;
                            we_q      <= 1'b1;
                            req_ready <= 1'b0;
                            state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    we_q      <= 1'b0;
                    imem_addr <= imem_addr + 1'b1;
                    count     <= count_inc;
                    if (last_q) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (count_inc == DEPTH_C) begin
                        full  <= 1'b1;
                        state <= S_FULL;
                    end else begin
                        req_ready <= 1'b1;
                        state     <= S_ACCEPT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=64 and DEPTH=4 instances).
module tb_instr_encoder;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_kind = 4'd0;
    logic [4:0]  req_rs = 5'd0, req_rt = 5'd0, req_rd = 5'd0;
    logic [15:0] req_imm = 16'd0;
    logic [25:0] req_target = 26'd0;
    logic        req_last = 1'b0;

    logic        ready_a, we_a, done_a, full_a, err_a;
    logic [5:0]  addr_a;
    logic [31:0] wd_a;
    logic [6:0]  count_a;

    logic        ready_b, we_b, done_b, full_b, err_b;
    logic [2:0]  addr_b;
    logic [31:0] wd_b;
    logic [3:0]  count_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(6), .DEPTH(64)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .req_valid(req_valid),
        .req_ready(ready_a), .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt),
        .req_rd(req_rd), .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wd(wd_a), .count(count_a),
        .done(done_a), .full(full_a), .err(err_a)
    );

    instr_encoder #(.ADDR_W(3), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .req_valid(req_valid),
        .req_ready(ready_b), .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt),
        .req_rd(req_rd), .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wd(wd_b), .count(count_b),
        .done(done_b), .full(full_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Enter and leave on a negedge; checks the WRITE cycle of the main instance
    // and, when c4 is set, of the DEPTH=4 instance as well.
    task automatic send(input string tag, input logic [3:0] kind, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last,
                        input logic [5:0] exp_addr, input logic [31:0] exp_wd, input bit c4);
        int n = 0;
        while (!ready_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, {31'd0, ready_a}, 32'd1);
        req_valid = 1'b1; req_kind = kind; req_rs = rs; req_rt = rt; req_rd = rd;
        req_imm = imm; req_target = tgt; req_last = last;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, " we"},       {31'd0, we_a}, 32'd1);
        check({tag, " addr"},     {26'd0, addr_a}, {26'd0, exp_addr});
        check({tag, " wd"},       wd_a, exp_wd);
        check({tag, " ready_wr"}, {31'd0, ready_a}, 32'd0);
        if (c4) begin
            check({tag, " we4"},   {31'd0, we_b}, 32'd1);
            check({tag, " addr4"}, {29'd0, addr_b}, {26'd0, exp_addr});
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst ready", {31'd0, ready_a}, 32'd0);
        check("rst we",    {31'd0, we_a}, 32'd0);
        check("rst addr",  {26'd0, addr_a}, 32'd0);
        check("rst wd",    wd_a, 32'd0);
        check("rst count", {25'd0, count_a}, 32'd0);
        check("rst flags", {28'd0, done_a, full_a, err_a, 1'b0}, 32'd0);
        reset_n = 1'b1;

        // IDLE ignores requests
        req_valid = 1'b1; req_kind = K_ADD;
        repeat (2) @(negedge clk);
        check("idle we",    {31'd0, we_a}, 32'd0);
        check("idle ready", {31'd0, ready_a}, 32'd0);
        req_valid = 1'b0;

        // Single ADD
        pulse_start();
        check("start ready", {31'd0, ready_a}, 32'd1);
        send("add", K_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 6'd0, 32'h0022_1820, 1'b0);
        check("add count", {25'd0, count_a}, 32'd1);

        // Five-word program ending in J with last
        pulse_start();
        send("lw",   K_LW,   5'd0, 5'd2, 5'd0, 16'h0004, 26'd0, 1'b0, 6'd0, 32'h8C02_0004, 1'b0);
        send("sw",   K_SW,   5'd3, 5'd2, 5'd0, 16'h0008, 26'd0, 1'b0, 6'd1, 32'hAC62_0008, 1'b0);
        send("beq",  K_BEQ,  5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b0, 6'd2, 32'h1022_FFFF, 1'b0);
        send("addi", K_ADDI, 5'd0, 5'd4, 5'd0, 16'h0005, 26'd0, 1'b0, 6'd3, 32'h2004_0005, 1'b0);
        send("j",    K_J,    5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1, 6'd4, 32'h0800_0010, 1'b0);
        check("prog done",  {31'd0, done_a}, 32'd1);
        check("prog count", {25'd0, count_a}, 32'd5);
        check("prog ready", {31'd0, ready_a}, 32'd0);
        check("prog full",  {31'd0, full_a}, 32'd0);
        req_valid = 1'b1; req_kind = K_ADD;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        check("done hold we",    {31'd0, we_a}, 32'd0);
        check("done hold count", {25'd0, count_a}, 32'd5);

        // Illegal kind mid-stream; DEPTH=4 instance fills with four legal words
        pulse_start();
        send("sub", K_SUB, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 1'b0, 6'd0, 32'h0085_3022, 1'b1);
        req_valid = 1'b1; req_kind = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        check("ill we",    {31'd0, we_a}, 32'd0);
        check("ill err",   {31'd0, err_a}, 32'd1);
        check("ill ready", {31'd0, ready_a}, 32'd1);
        check("ill addr",  {26'd0, addr_a}, 32'd1);
        send("and", K_AND, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0, 1'b0, 6'd1, 32'h0021_0824, 1'b1);
        check("err sticky", {31'd0, err_a}, 32'd1);
        send("or",  K_OR,  5'd7, 5'd8, 5'd9, 16'd0, 26'd0, 1'b0, 6'd2, 32'h00E8_4825, 1'b1);
        send("slt", K_SLT, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0, 1'b0, 6'd3, 32'h0043_202A, 1'b1);
        check("d4 full",   {31'd0, full_b}, 32'd1);
        check("d4 done",   {31'd0, done_b}, 32'd0);
        check("d4 ready",  {31'd0, ready_b}, 32'd0);
        check("d4 count",  {28'd0, count_b}, 32'd4);
        check("d64 full",  {31'd0, full_a}, 32'd0);
        check("d64 ready", {31'd0, ready_a}, 32'd1);

        // start clears FULL; next word lands at address 0
        pulse_start();
        check("d4 full clr",  {31'd0, full_b}, 32'd0);
        check("d4 count clr", {28'd0, count_b}, 32'd0);
        check("err clr",      {31'd0, err_a}, 32'd0);
        send("d4 restart", K_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 6'd0, 32'h0022_1820, 1'b1);

        // last on the DEPTH-th word: DONE wins
        pulse_start();
        send("w0", K_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 6'd0, 32'h0022_1820, 1'b1);
        send("w1", K_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 6'd1, 32'h0022_1820, 1'b1);
        send("w2", K_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 6'd2, 32'h0022_1820, 1'b1);
        send("w3", K_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1, 6'd3, 32'h0022_1820, 1'b1);
        check("d4 last done", {31'd0, done_b}, 32'd1);
        check("d4 last full", {31'd0, full_b}, 32'd0);

        // start during WRITE drops the word
        pulse_start();
        send("pre", K_ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 6'd0, 32'h0022_1820, 1'b0);
        req_valid = 1'b1; req_kind = K_SUB; req_last = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        start = 1'b1;
        #1;
        check("sw we", {31'd0, we_a}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("sw addr",  {26'd0, addr_a}, 32'd0);
        check("sw count", {25'd0, count_a}, 32'd0);
        check("sw ready", {31'd0, ready_a}, 32'd1);
        send("after sw", K_OR, 5'd7, 5'd8, 5'd9, 16'd0, 26'd0, 1'b0, 6'd0, 32'h00E8_4825, 1'b0);

        // reset during WRITE
        req_valid = 1'b1; req_kind = K_AND;
        @(negedge clk);
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rw we", {31'd0, we_a}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check("rw ready", {31'd0, ready_a}, 32'd0);
        check("rw addr",  {26'd0, addr_a}, 32'd0);
        check("rw count", {25'd0, count_a}, 32'd0);
        check("rw wd",    wd_a, 32'd0);
        req_valid = 1'b1; req_kind = K_ADD;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        check("rw idle we",    {31'd0, we_a}, 32'd0);
        check("rw idle count", {25'd0, count_a}, 32'd0);
        pulse_start();
        send("after rst", K_SLT, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0, 1'b0, 6'd0, 32'h0043_202A, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential MIPS instruction encoder: the inverse of the op/funct control decode. Accepts symbolic instruction requests over a valid/ready handshake, packs each one into a 32-bit MIPS word, and writes the words to consecutive instruction-memory addresses through a single write port. It is used to load programs into the single-cycle core's instruction memory from a testbench or boot sequencer, using the same opcode/funct encodings the core decodes.

Parameters:
ADDR_W, 6, instruction-memory word-address width
DEPTH, 64, number of writable words; must satisfy DEPTH <= 2**ADDR_W

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous, active-low reset
start  input  1  pulse: begin a new program at address 0
req_valid  input  1  request present
req_ready  output  1  encoder can accept a request this cycle
req_kind  input  4  instr_kind_t: ADD, SUB, AND, OR, SLT, LW, SW, BEQ, ADDI, J; other codes illegal
req_rs  input  5  source register
req_rt  input  5  second source / destination for I-type
req_rd  input  5  destination for R-type
req_imm  input  16  I-type immediate, passed through unmodified
req_target  input  26  J-type word target
req_last  input  1  this request is the final instruction
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_W  write word address
imem_wd  output  32  encoded instruction word
count  output  ADDR_W+1  words written since start
done  output  1  program complete (last word written)
full  output  1  DEPTH words written without req_last
err  output  1  sticky: illegal req_kind seen

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE; req_ready=0, imem_we=0, imem_addr=0, imem_wd=0, count=0, done=0, full=0, err=0. Reset mid-write drops the pending word.
- States: IDLE, ACCEPT, WRITE, DONE, FULL. Only ACCEPT drives req_ready=1.
- start has priority in every state: the next state is ACCEPT, and address, count, done, full and err are cleared. A word pending in WRITE is dropped and imem_we stays 0 that cycle.
- Handshake: a transfer occurs when req_valid & req_ready at a rising edge. The encoded word and the last flag are registered, and the state moves to WRITE. Request inputs are don't-care outside a transfer.
- Illegal req_kind on a transfer: no word is stored, err is set to 1 (sticky), and the state stays ACCEPT.
- WRITE lasts exactly one cycle: imem_we=1 with the registered imem_addr and imem_wd. At the end of the cycle imem_addr and count increment. Next state:
  - DONE if the last flag is set (done=1);
  - otherwise FULL if count reaches DEPTH (full=1);
  - otherwise ACCEPT.
  - Last flag on the DEPTH-th word: DONE wins and full stays 0.
- Latency: transfer edge N, then imem_we high during cycle N+1. Maximum throughput is 1 word per 2 cycles.
- DONE and FULL hold all outputs, with req_ready=0, until start or reset.
- Encoding, with fields op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6]=0, funct[5:0]:
  - R-type (op 000000): funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - LW 100011, SW 101011, BEQ 000100, ADDI 001000: layout {op, rs, rt, imm}.
  - J 000010: layout {op, target}.
- imem_addr wraps only via start; it never exceeds DEPTH-1 while imem_we is asserted.

Decomposition:
- Package mips_pkg holds:
  - the 6-bit opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - the funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT;
  - instr_kind_t (4-bit enum) and the encoder state enum.
- The opcode and funct constants are shared with the main and ALU decoders.
- One combinational sub-module, instr_pack, maps kind plus fields to {word, illegal}. The top level holds the FSM, the address/count registers and the output registers.

Test Plan:
- Reset, then start; ADD rs=1 rt=2 rd=3 with last=0 -> imem_we in the cycle after the transfer, addr 0, wd 0x00221820; count=1; req_ready=0 during WRITE.
- Sequence LW rt=2 rs=0 imm=4; SW rt=2 rs=3 imm=8; BEQ rs=1 rt=2 imm=0xFFFF; ADDI rt=4 rs=0 imm=5; J target=0x10 with last=1 -> words 0x8C020004, 0xAC620008, 0x1022FFFF, 0x20040005, 0x08000010 at addrs 0-4; done=1, count=5, req_ready=0 afterwards.
- req_kind=0xF mid-stream -> no imem_we, err=1 and remains 1; the next legal request is written at the unchanged address.
- DEPTH=4, four requests with last=0 -> full=1, done=0, req_ready=0; then start -> full=0, count=0, next word at addr 0. Separately, last=1 on the 4th request -> done=1, full=0.
- start asserted in the WRITE cycle -> imem_we=0 that cycle, addr/count=0, state ACCEPT; the next request is written at addr 0.
- reset_n=0 for one cycle during WRITE -> all outputs at reset values next cycle and state IDLE; req_valid is ignored until start.
